actuation_vote_unit: RTL and testbench
======================================

# actuation_vote_unit

Consumer end of the instrumentation trip path. Accepts per-division sensor-trip vectors from the instrumentation units over a valid/ready handshake and holds the latest vector per division. Forms a 2-out-of-NDivisions coincidence vote per channel and drives sealed-in actuation commands to the two actuation devices. A division that stops reporting is treated as fully tripped (fail-safe).

## Interface
- NDivisions, 4: number of instrumentation divisions voted.
- NChannels, 3: trip channels per division; index 0 temperature, 1 pressure, 2 saturation.
- Timeout, 1000: cycles without an accepted update before a division is stale; must be ≥2.
- TW, $clog2(Timeout+1): staleness counter width.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- trip_in  in  NDivisions*NChannels  trip vectors; division d occupies bits [NChannels*d +: NChannels]; bit c = channel c tripped.
- trip_valid  in  NDivisions  division d presents a vector.
- trip_ready  out  NDivisions  division d may transfer.
- manual_trip  in  2  operator trip request per device.
- reset_req  in  1  operator request to release sealed-in actuation.
- vote  out  NChannels  registered per-channel coincidence result.
- stale  out  NDivisions  division d has timed out.
- actuate  out  2  actuation command; bit 0 = device 0, bit 1 = device 1.

## Operation
- Reset: all latched vectors 0, counters 0, stale 0, vote 0, actuate 0, trip_ready 0. trip_ready goes 1 on the first edge after rst deasserts and then stays 1. The vote unit never back-pressures.
- Transfer: on an edge with trip_valid[d] & trip_ready[d], latch that division's slice and clear counter d to 0.
- Staleness: with no transfer, counter d increments and saturates at Timeout. stale[d] = (counter == Timeout). It clears on the edge of the next transfer.
- Effective trip for division d, channel c: latched[d][c] | stale[d].
- Coincidence: a channel's vote is 1 when at least 2 divisions have an effective trip on that channel. The count uses a $clog2(NDivisions+1)-bit population count, compared ≥2.
- Device demand:
  - dem0 = vote[0] | vote[1] | manual_trip[0].
  - dem1 = vote[2] | manual_trip[1].
- Per-device FSM, two states:
  - IDLE (actuate=0): dem → SEALED.
  - SEALED (actuate=1): reset_req & !dem → IDLE. Otherwise it stays SEALED, even after the trips clear.
  - reset_req in IDLE: no effect.
  - reset_req on the same edge that dem rises: demand wins and the device stays or goes SEALED.
- Reset mid-operation: asynchronous clear to the reset values above. SEALED is lost, which is intended; the power-on state is IDLE.
- Bypass/maintenance mode are folded in upstream. This block sees only tripped bits.

## Timing
- Transfer accepted at edge k: latched vector and counter update at k; vote updates at k+1; actuate rises at k+2. Worst-case latency from trip_valid to actuate is 2 edges.
- manual_trip sampled at edge k: actuate rises at k+1 (it bypasses the vote register).
- Staleness: stale[d] rises exactly Timeout edges after the last transfer. The stale-driven vote follows 1 edge later, and actuate 1 edge after that.
- reset_req sampled at edge k with dem low: actuate falls at k+1. dem is evaluated from the registered vote and manual_trip at k.
- Transfers on multiple divisions on the same edge are all accepted; there is no arbitration.

## Structure
- Package rts_actuation_pkg:
  - channel index constants CH_T=0, CH_P=1, CH_S=2;
  - device index constants DEV0=0, DEV1=1;
  - enum act_state_t {IDLE, SEALED};
  - a popcount function for coincidence.
- Sub-module division_watchdog, instantiated NDivisions times. It holds the handshake, the vector latch, the saturating counter and the stale flag, and outputs the effective trip vector.
- The top level contains only the vote registers and the two device FSMs.

## Test plan
- Reset release: rst high 3 cycles then low → all outputs 0 during reset; trip_ready=4'b1111 one edge after release.
- 2oo4 vote: divisions 0 and 2 send 3'b001, others 3'b000 → vote=3'b001 after one edge, actuate=2'b01 after two. A single division with 3'b001 → actuate stays 0.
- Seal-in and release:
  - After the above, all divisions send 3'b000 → actuate stays 2'b01.
  - reset_req pulsed → actuate=0 one edge later.
  - reset_req held while division 1 and 3 send 3'b100 → actuate=2'b10 and does not clear.
- Staleness: Timeout=8; divisions 0 and 1 stop sending while 2 and 3 update every cycle with 0 → stale=4'b0011 at edge 8, vote=3'b111 at edge 9, actuate=2'b11 at edge 10. A new transfer on division 0 clears stale[0] on that edge.
- Manual trip: manual_trip=2'b10 for one cycle with no sensor trips → actuate=2'b10 next edge and held. reset_req → cleared.
- Async reset while SEALED: rst asserted mid-cycle → actuate=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rts_actuation_pkg.sv
// Shared definitions for the reactor-trip actuation vote path: channel and
// device indices, the per-device seal-in state and the coincidence popcount.
package rts_actuation_pkg;

  localparam int CH_T = 0;
  localparam int CH_P = 1;
  localparam int CH_S = 2;

  localparam int DEV0 = 0;
  localparam int DEV1 = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SEALED = 1'b1
  } act_state_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/division_watchdog.sv
// One instrumentation division: always-ready handshake, latest trip vector,
// saturating silence counter and the fail-safe effective trip vector.
module division_watchdog #(
  parameter int NChannels = 3,
  parameter int Timeout   = 1000,
  parameter int TW        = $clog2(Timeout + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NChannels-1:0] trip_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 stale_o,
  output logic [NChannels-1:0] eff_trip_o
);

  localparam logic [TW-1:0] TMAX = TW'(Timeout);

  logic                 ready_q;
  logic [NChannels-1:0] lat_q, lat_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 xfer;

  assign xfer = valid_i & ready_q;

  always_comb begin
    lat_d = lat_q;
    cnt_d = cnt_q;
    if (xfer) begin
      lat_d = trip_i;
      cnt_d = '0;
    end else if (cnt_q != TMAX) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  // A silent division votes as tripped on every channel.
  assign stale_o    = (cnt_q == TMAX);
  assign eff_trip_o = lat_q | {NChannels{stale_o}};
  assign ready_o    = ready_q;

endmodule

// File: rtl/actuation_vote_unit.sv
// 2-out-of-N coincidence vote per trip channel feeding two sealed-in
// actuation devices; releasing a device needs reset_req with demand gone.
module actuation_vote_unit
  import rts_actuation_pkg::*;
#(
  parameter int NDivisions = 4,
  parameter int NChannels  = 3,
  parameter int Timeout    = 1000,
  parameter int TW         = $clog2(Timeout + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NDivisions*NChannels-1:0] trip_in,
  input  logic [NDivisions-1:0]           trip_valid,
  output logic [NDivisions-1:0]           trip_ready,
  input  logic [1:0]                      manual_trip,
  input  logic                            reset_req,
  output logic [NChannels-1:0]            vote,
  output logic [NDivisions-1:0]           stale,
  output logic [1:0]                      actuate
);

  localparam int CW = $clog2(NDivisions + 1);

  logic [NDivisions*NChannels-1:0] eff_flat;
  logic [NDivisions-1:0]           col [NChannels];
  logic [NChannels-1:0]            vote_q, vote_d;
  logic [1:0]                      dem;
  act_state_t                      st_q [2];
  act_state_t                      st_d [2];

  for (genvar d = 0; d < NDivisions; d++) begin : g_div
    division_watchdog #(
      .NChannels(NChannels),
      .Timeout  (Timeout),
      .TW       (TW)
    ) u_wd (
      .clk       (clk),
      .rst       (rst),
      .trip_i    (trip_in[NChannels*d +: NChannels]),
      .valid_i   (trip_valid[d]),
      .ready_o   (trip_ready[d]),
      .stale_o   (stale[d]),
      .eff_trip_o(eff_flat[NChannels*d +: NChannels])
    );
  end

  // Regroup effective trips by channel for the coincidence count.
  for (genvar c = 0; c < NChannels; c++) begin : g_col
    for (genvar d = 0; d < NDivisions; d++) begin : g_bit
      assign col[c][d] = eff_flat[NChannels*d + c];
    end
  end

  always_comb begin
    vote_d = '0;
    for (int c = 0; c < NChannels; c++) begin
      vote_d[c] = (CW'(popcount(32'(col[c]))) >= CW'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= '0;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign vote = vote_q;

  // Manual trip bypasses the vote register for one-edge response.
  assign dem[DEV0] = vote_q[CH_T] | vote_q[CH_P] | manual_trip[DEV0];
  assign dem[DEV1] = vote_q[CH_S] | manual_trip[DEV1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) st_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < 2; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        IDLE:    if (dem[i]) st_d[i] = SEALED;
        SEALED:  if (reset_req && !dem[i]) st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    actuate = '0;
    for (int i = 0; i < 2; i++) begin
      actuate[i] = (st_q[i] == SEALED);
    end
  end

endmodule

// File: tb/tb_actuation_vote_unit.sv
// Directed and randomized checks of actuation_vote_unit against a
// cycle-level behavioural model of the vote and seal-in rules.
module tb_actuation_vote_unit;

  localparam int ND = 4;
  localparam int NC = 3;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ND*NC-1:0]  trip_in;
  logic [ND-1:0]     trip_valid;
  logic [ND-1:0]     trip_ready;
  logic [1:0]        manual_trip;
  logic              reset_req;
  logic [NC-1:0]     vote;
  logic [ND-1:0]     stale;
  logic [1:0]        actuate;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [NC-1:0] m_lat [ND];
  int            m_age [ND];
  logic [NC-1:0] m_vote;
  logic [1:0]    m_act;
  logic          m_ready;

  actuation_vote_unit #(
    .NDivisions(ND),
    .NChannels (NC),
    .Timeout   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trip_in    (trip_in),
    .trip_valid (trip_valid),
    .trip_ready (trip_ready),
    .manual_trip(manual_trip),
    .reset_req  (reset_req),
    .vote       (vote),
    .stale      (stale),
    .actuate    (actuate)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_lat[d] = '0;
      m_age[d] = 0;
    end
    m_vote  = '0;
    m_act   = '0;
    m_ready = 1'b0;
  endtask

  // One rising edge of the specified behaviour, all from pre-edge state.
  task automatic model_edge();
    logic [NC-1:0] eff [ND];
    logic [NC-1:0] nv;
    logic [1:0]    dem;
    int            n;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++)
      eff[d] = m_lat[d] | ((m_age[d] == TO) ? {NC{1'b1}} : {NC{1'b0}});
    for (int c = 0; c < NC; c++) begin
      n = 0;
      for (int d = 0; d < ND; d++) if (eff[d][c]) n++;
      nv[c] = (n >= 2);
    end
    dem[0] = m_vote[0] | m_vote[1] | manual_trip[0];
    dem[1] = m_vote[2] | manual_trip[1];
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i]) begin
        if (dem[i]) m_act[i] = 1'b1;
      end else if (reset_req && !dem[i]) begin
        m_act[i] = 1'b0;
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (trip_valid[d] && m_ready) begin
        m_lat[d] = trip_in[NC*d +: NC];
        m_age[d] = 0;
      end else if (m_age[d] < TO) begin
        m_age[d]++;
      end
    end
    m_vote  = nv;
    m_ready = 1'b1;
  endtask

  task automatic compare_all();
    logic [ND-1:0] es;
    for (int d = 0; d < ND; d++) es[d] = (m_age[d] == TO);
    check_eq("ready", 32'(trip_ready), 32'({ND{m_ready}}));
    check_eq("stale", 32'(stale), 32'(es));
    check_eq("vote", 32'(vote), 32'(m_vote));
    check_eq("actuate", 32'(actuate), 32'(m_act));
  endtask

  task automatic step(input logic [ND*NC-1:0] t, input logic [ND-1:0] v,
                      input logic [1:0] m, input logic r);
    trip_in     = t;
    trip_valid  = v;
    manual_trip = m;
    reset_req   = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [ND*NC-1:0] tv(input logic [2:0] d3, input logic [2:0] d2,
                                         input logic [2:0] d1, input logic [2:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    logic [ND-1:0] silent;
    logic [ND*NC-1:0] t;
    logic [ND-1:0] v;
    rst = 1'b1;
    trip_in = '0;
    trip_valid = '0;
    manual_trip = '0;
    reset_req = 1'b0;
    model_reset();

    // Reset held for 3 edges, then released
    for (int i = 0; i < 3; i++) step('0, '0, 2'b00, 1'b0);
    rst = 1'b0;
    step('0, 4'hF, 2'b00, 1'b0);
    check_eq("ready_after_release", 32'(trip_ready), 32'hF);

    // 2oo4 on temperature
    step(tv(3'b000, 3'b001, 3'b000, 3'b001), 4'hF, 2'b00, 1'b0);
    step(tv(3'b000, 3'b001, 3'b000, 3'b001), 4'hF, 2'b00, 1'b0);
    check_eq("vote_2oo4", 32'(vote), 32'h1);
    step(tv(3'b000, 3'b001, 3'b000, 3'b001), 4'hF, 2'b00, 1'b0);
    check_eq("act_2oo4", 32'(actuate), 32'h1);

    // Trips clear: seal-in holds, then reset_req releases
    for (int i = 0; i < 3; i++) step('0, 4'hF, 2'b00, 1'b0);
    check_eq("sealed_hold", 32'(actuate), 32'h1);
    step('0, 4'hF, 2'b00, 1'b1);
    check_eq("release", 32'(actuate), 32'h0);

    // Single division cannot actuate
    for (int i = 0; i < 3; i++) step(tv(3'b000, 3'b000, 3'b000, 3'b001), 4'hF, 2'b00, 1'b0);
    check_eq("single_div", 32'(actuate), 32'h0);

    // Demand beats a held reset_req
    for (int i = 0; i < 4; i++) step(tv(3'b100, 3'b000, 3'b100, 3'b000), 4'hF, 2'b00, 1'b1);
    check_eq("demand_wins", 32'(actuate), 32'h2);
    for (int i = 0; i < 3; i++) step('0, 4'hF, 2'b00, 1'b1);
    check_eq("release_dev1", 32'(actuate), 32'h0);
    step('0, 4'hF, 2'b00, 1'b0);

    // Divisions 0 and 1 fall silent
    for (int i = 1; i <= 7; i++) step('0, 4'b1100, 2'b00, 1'b0);
    check_eq("stale_before", 32'(stale), 32'h0);
    step('0, 4'b1100, 2'b00, 1'b0);
    check_eq("stale_at_to", 32'(stale), 32'h3);
    step('0, 4'b1100, 2'b00, 1'b0);
    check_eq("stale_vote", 32'(vote), 32'h7);
    step('0, 4'b1100, 2'b00, 1'b0);
    check_eq("stale_act", 32'(actuate), 32'h3);
    step('0, 4'b1101, 2'b00, 1'b0);
    check_eq("stale_clear", 32'(stale), 32'h2);
    step('0, 4'hF, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step('0, 4'hF, 2'b00, 1'b1);
    check_eq("stale_release", 32'(actuate), 32'h0);

    // Manual trip on device 1
    step('0, 4'hF, 2'b10, 1'b0);
    check_eq("manual_act", 32'(actuate), 32'h2);
    for (int i = 0; i < 2; i++) step('0, 4'hF, 2'b00, 1'b0);
    check_eq("manual_hold", 32'(actuate), 32'h2);
    step('0, 4'hF, 2'b00, 1'b1);
    check_eq("manual_release", 32'(actuate), 32'h0);

    // Asynchronous reset while sealed
    step('0, 4'hF, 2'b01, 1'b0);
    check_eq("seal_before_rst", 32'(actuate), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_act", 32'(actuate), 32'h0);
    check_eq("async_ready", 32'(trip_ready), 32'h0);
    model_reset();
    @(negedge clk);
    step('0, '0, 2'b00, 1'b0);
    rst = 1'b0;
    step('0, 4'hF, 2'b00, 1'b0);

    // Randomized traffic with divisions going silent now and then
    silent = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 39) == 0) silent[d] = ~silent[d];
        v[d] = !silent[d] && ($urandom_range(0, 7) != 0);
        for (int c = 0; c < NC; c++) t[NC*d + c] = ($urandom_range(0, 4) == 0);
      end
      step(t, v, ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
